// File: rtl/fht_but_array.sv
// FHT butterfly array: pairs a two-beat bank read into NB butterflies, then
// rotates, adds/subtracts, optionally halves, saturates and reorders the results.
module fht_but_array #(
  parameter int unsigned NB    = 2,
  parameter int unsigned D_BIT = 17,
  parameter int unsigned W_BIT = 12
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iVALID,
  input  logic                    iBEAT,
  input  logic                    iST_ZERO,
  input  logic                    iST_LAST,
  input  logic                    i2ND_PART_SUBSEC,
  input  logic                    iSCALE,
  input  logic                    iCLR_OVF,
  input  logic [2*NB*D_BIT-1:0]   iBANK,
  input  logic [NB*W_BIT-1:0]     iCOS,
  input  logic [NB*W_BIT-1:0]     iSIN,
  output logic [2*NB*D_BIT-1:0]   oY,
  output logic                    oVALID,
  output logic                    oOVF,
  output logic                    oERR
);

  localparam int unsigned NL = 2 * NB;
  localparam int unsigned BW = NL * D_BIT;
  localparam int unsigned PW = D_BIT + W_BIT + 1;
  localparam int unsigned SH = W_BIT - 2;
  localparam int unsigned TW = D_BIT + 2;
  localparam int unsigned RW = D_BIT + 3;

  localparam logic signed [PW-1:0] RND   = PW'(2 ** (W_BIT - 3));
  localparam logic signed [RW-1:0] Y_MAX = RW'(2 ** (D_BIT - 1) - 1);
  localparam logic signed [RW-1:0] Y_MIN = -RW'(2 ** (D_BIT - 1));

  logic                    beat_a_c, beat_b_c, cap_c;

  logic                    pending;
  logic signed [D_BIT-1:0] a_x2 [NB];
  logic signed [D_BIT-1:0] a_x3 [NB];

  logic                    s0_vld, s0_zero, s0_last, s0_2nd, s0_scale;
  logic signed [D_BIT-1:0] s0_x1 [NB];
  logic signed [D_BIT-1:0] s0_x2 [NB];
  logic signed [D_BIT-1:0] s0_x3 [NB];
  logic signed [W_BIT-1:0] s0_cos [NB];
  logic signed [W_BIT-1:0] s0_sin [NB];

  logic signed [PW-1:0]    acc_c [NB];
  logic signed [TW-1:0]    t_c [NB];

  logic                    s1_vld, s1_last, s1_2nd, s1_scale;
  logic signed [D_BIT-1:0] s1_x1 [NB];
  logic signed [TW-1:0]    s1_t [NB];

  logic signed [RW-1:0]    sum0_c [NB];
  logic signed [RW-1:0]    sum1_c [NB];
  logic signed [D_BIT-1:0] y0_c [NB];
  logic signed [D_BIT-1:0] y1_c [NB];
  logic                    sat_c;

  logic                    s2_vld, s2_last, s2_2nd, s2_sat;
  logic signed [D_BIT-1:0] s2_y0 [NB];
  logic signed [D_BIT-1:0] s2_y1 [NB];

  logic [BW-1:0]           mix_c;

  function automatic logic signed [D_BIT-1:0] clip(input logic signed [RW-1:0] v);
    if (v > Y_MAX) return D_BIT'(Y_MAX);
    if (v < Y_MIN) return D_BIT'(Y_MIN);
    return D_BIT'(v);
  endfunction

  function automatic logic clipped(input logic signed [RW-1:0] v);
    return (v > Y_MAX) || (v < Y_MIN);
  endfunction

  assign beat_a_c = iVALID & ~iBEAT;
  assign beat_b_c = iVALID &  iBEAT;
  assign cap_c    = beat_b_c & pending;

  // Beat A holding registers and pairing flag; a lone beat B is reported, not used
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pending <= 1'b0;
      oERR    <= 1'b0;
      a_x2    <= '{default: '0};
      a_x3    <= '{default: '0};
    end else begin
      oERR <= beat_b_c & ~pending;
      if (beat_a_c) begin
        pending <= 1'b1;
        for (int unsigned k = 0; k < NB; k++) begin
          a_x2[k] <= $signed(iBANK[2*k*D_BIT +: D_BIT]);
          a_x3[k] <= $signed(iBANK[(2*k+1)*D_BIT +: D_BIT]);
        end
      end else if (beat_b_c) begin
        pending <= 1'b0;
      end
    end
  end

  // Stage 0: beat B capture together with its twiddles and mode flags
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      s0_vld   <= 1'b0;
      s0_zero  <= 1'b0;
      s0_last  <= 1'b0;
      s0_2nd   <= 1'b0;
      s0_scale <= 1'b0;
      s0_x1    <= '{default: '0};
      s0_x2    <= '{default: '0};
      s0_x3    <= '{default: '0};
      s0_cos   <= '{default: '0};
      s0_sin   <= '{default: '0};
    end else begin
      s0_vld <= cap_c;
      if (cap_c) begin
        s0_zero  <= iST_ZERO;
        s0_last  <= iST_LAST;
        s0_2nd   <= i2ND_PART_SUBSEC;
        s0_scale <= iSCALE;
        for (int unsigned k = 0; k < NB; k++) begin
          s0_x1[k]  <= $signed(iBANK[2*k*D_BIT +: D_BIT]);
          s0_x2[k]  <= a_x2[k];
          s0_x3[k]  <= a_x3[k];
          s0_cos[k] <= $signed(iCOS[k*W_BIT +: W_BIT]);
          s0_sin[k] <= $signed(iSIN[k*W_BIT +: W_BIT]);
        end
      end
    end
  end

  // Rotation term, rounded to nearest before dropping the twiddle fraction
  always_comb begin
    acc_c = '{default: '0};
    t_c   = '{default: '0};
    for (int unsigned k = 0; k < NB; k++) begin
      acc_c[k] = PW'(s0_x2[k]) * PW'(s0_cos[k]) + PW'(s0_x3[k]) * PW'(s0_sin[k]) + RND;
      t_c[k]   = s0_zero ? TW'(s0_x2[k]) : TW'(acc_c[k] >>> SH);
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_2nd   <= 1'b0;
      s1_scale <= 1'b0;
      s1_x1    <= '{default: '0};
      s1_t     <= '{default: '0};
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_last  <= s0_last;
        s1_2nd   <= s0_2nd;
        s1_scale <= s0_scale;
        s1_x1    <= s0_x1;
        s1_t     <= t_c;
      end
    end
  end

  // One bit of headroom above the sum width keeps the +1 of the halving exact
  always_comb begin
    sum0_c = '{default: '0};
    sum1_c = '{default: '0};
    y0_c   = '{default: '0};
    y1_c   = '{default: '0};
    sat_c  = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      sum0_c[k] = RW'(s1_x1[k]) + RW'(s1_t[k]);
      sum1_c[k] = RW'(s1_x1[k]) - RW'(s1_t[k]);
      if (s1_scale) begin
        sum0_c[k] = (sum0_c[k] + RW'(1)) >>> 1;
        sum1_c[k] = (sum1_c[k] + RW'(1)) >>> 1;
      end
      y0_c[k] = clip(sum0_c[k]);
      y1_c[k] = clip(sum1_c[k]);
      sat_c   = sat_c | clipped(sum0_c[k]) | clipped(sum1_c[k]);
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_2nd  <= 1'b0;
      s2_sat  <= 1'b0;
      s2_y0   <= '{default: '0};
      s2_y1   <= '{default: '0};
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_last <= s1_last;
        s2_2nd  <= s1_2nd;
        s2_sat  <= sat_c;
        s2_y0   <= y0_c;
        s2_y1   <= y1_c;
      end
    end
  end

  // Write-back lane order: interleaved on the last stage, else split halves
  always_comb begin
    mix_c = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (s2_last) begin
        mix_c[2*j*D_BIT +: D_BIT]     = s2_y0[j];
        mix_c[(2*j+1)*D_BIT +: D_BIT] = s2_y1[j];
      end else if (s2_2nd) begin
        mix_c[j*D_BIT +: D_BIT]       = s2_y0[NB-1-j];
        mix_c[(NB+j)*D_BIT +: D_BIT]  = s2_y1[NB-1-j];
      end else begin
        mix_c[j*D_BIT +: D_BIT]       = s2_y0[j];
        mix_c[(NB+j)*D_BIT +: D_BIT]  = s2_y1[j];
      end
    end
  end

  // A saturation landing in the clearing cycle must not be lost
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oY     <= '0;
      oVALID <= 1'b0;
      oOVF   <= 1'b0;
    end else begin
      oVALID <= s2_vld;
      if (s2_vld) oY <= mix_c;
      if (s2_vld && s2_sat) oOVF <= 1'b1;
      else if (iCLR_OVF)    oOVF <= 1'b0;
    end
  end

endmodule
